// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: the master drives the request
// side, and the ALU (slave) returns ready, result, zero and error flags.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             err_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  ready_o, valid_o, data_o, zero_o, err_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output ready_o, valid_o, data_o, zero_o, err_o
    );
endinterface

// File: rtl/multicycle_alu.sv
// EX-stage execution unit: single-cycle Add/Sub/And/Or plus an iterative
// shift-add multiplier. Define MULT_EARLY_TERM_EN to let Mult stop early.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_alu_if.slave  bus
);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b100;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_zero;
    logic             r_err;

    logic             w_accept;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_illegal;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_mplierNext;
    logic             w_lastIter;

    assign w_accept    = bus.valid_i && (r_state == IDLE);
    assign bus.ready_o = (r_state == IDLE);
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.zero_o  = r_zero;
    assign bus.err_o   = r_err;

    always_comb begin
        w_aluResult = '0;
        w_illegal   = 1'b0;
        case (bus.ALUCtrl_i)
            OP_ADD:  w_aluResult = bus.data1_i + bus.data2_i;
            OP_SUB:  w_aluResult = bus.data1_i - bus.data2_i;
            OP_AND:  w_aluResult = bus.data1_i & bus.data2_i;
            OP_OR:   w_aluResult = bus.data1_i | bus.data2_i;
            OP_MUL:  w_aluResult = '0;
            default: w_illegal   = 1'b1;
        endcase
    end

    // One shift-add step; the multiplier's low bit decides whether to add.
    always_comb begin
        w_accNext    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_mplierNext = r_mplier >> 1;
`ifdef MULT_EARLY_TERM_EN
        w_lastIter   = (r_cnt == LAST_ITER) || (w_mplierNext == '0);
`else
        w_lastIter   = (r_cnt == LAST_ITER);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.ALUCtrl_i == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= bus.data1_i;
                            r_mplier <= bus.data2_i;
                            r_cnt    <= '0;
                            r_state  <= MUL;
                        end else begin
                            r_data  <= w_aluResult;
                            r_zero  <= (w_aluResult == '0);
                            r_valid <= 1'b1;
                            r_err   <= w_illegal;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplierNext;
                    r_cnt    <= r_cnt + 1'b1;
                    // Result leaves straight from the adder so ready rises with valid.
                    if (w_lastIter) begin
                        r_data  <= w_accNext;
                        r_zero  <= (w_accNext == '0);
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised self-checking bench for multicycle_alu against a behavioural
// model; honours MULT_EARLY_TERM_EN for expected Mult latency.
module tb_multicycle_alu;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b100;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    int compareCount  = 0;
    int mismatchCount = 0;

    multicycle_alu_if #(.WIDTH(WIDTH)) bus ();

    multicycle_alu #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural reference: plain arithmetic on full-width values.
    function automatic logic [WIDTH-1:0] refResult(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_MUL:  return prod[WIDTH-1:0];
            default: return '0;
        endcase
    endfunction

    function automatic bit refIllegal(input logic [2:0] op);
        return !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL});
    endfunction

    // Latency in edges, counting the accept edge as the first.
    function automatic int refLatency(input logic [2:0] op, input logic [WIDTH-1:0] b);
        int bitsUsed;
        if (op != OP_MUL) return 1;
        bitsUsed = 0;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) bitsUsed = i + 1;
`ifdef MULT_EARLY_TERM_EN
        return 1 + ((bitsUsed < 1) ? 1 : bitsUsed);
`else
        return WIDTH + 1;
`endif
    endfunction

    function automatic logic [2:0] randomOp();
        logic [2:0] ops [8];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, 3'b011, 3'b101, 3'b111};
        return ops[$urandom_range(0, 7)];
    endfunction

    // Entered just after a falling edge; returns just after the falling edge
    // following the result, unless busyTraffic leaves valid_i asserted.
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input bit busyTraffic);
        logic [WIDTH-1:0] expData;
        int               expLat;
        int               edges;
        int               readyLow;
        expData = refResult(op, a, b);
        expLat  = refLatency(op, b);
        checkOutput("readyBeforeAccept", 64'(bus.ready_o), 64'd1);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        @(posedge clk_i); #1;
        if (busyTraffic) begin
            bus.ALUCtrl_i = randomOp();
            bus.data1_i   = $urandom;
            bus.data2_i   = $urandom;
        end else begin
            bus.valid_i = 1'b0;
        end
        edges    = 1;
        readyLow = 0;
        while (!bus.valid_o && edges < 200) begin
            if (!bus.ready_o) readyLow++;
            @(posedge clk_i); #1;
            edges++;
            if (busyTraffic) begin
                bus.ALUCtrl_i = randomOp();
                bus.data1_i   = $urandom;
                bus.data2_i   = $urandom;
            end
        end
        checkOutput($sformatf("latency op=%b", op), 64'(edges), 64'(expLat));
        checkOutput("readyLowCycles", 64'(readyLow), 64'(expLat - 1));
        checkOutput("valid", 64'(bus.valid_o), 64'd1);
        checkOutput($sformatf("data op=%b a=%h b=%h", op, a, b), 64'(bus.data_o), 64'(expData));
        checkOutput("zero", 64'(bus.zero_o), 64'(expData == '0));
        checkOutput("err", 64'(bus.err_o), 64'(refIllegal(op)));
        checkOutput("readyWithValid", 64'(bus.ready_o), 64'd1);
        if (!busyTraffic) @(negedge clk_i);
    endtask

    logic [2:0]       tOp;
    logic [WIDTH-1:0] tA;
    logic [WIDTH-1:0] tB;
    int               stray;

    initial begin
        logic [2:0]       bbOp   [3];
        logic [WIDTH-1:0] bbA    [3];
        logic [WIDTH-1:0] bbB    [3];
        logic [WIDTH-1:0] bbRes;

        bus.valid_i   = 1'b0;
        bus.ALUCtrl_i = '0;
        bus.data1_i   = '0;
        bus.data2_i   = '0;

        #12;
        checkOutput("rstValid", 64'(bus.valid_o), 64'd0);
        checkOutput("rstData",  64'(bus.data_o),  64'd0);
        checkOutput("rstZero",  64'(bus.zero_o),  64'd1);
        checkOutput("rstErr",   64'(bus.err_o),   64'd0);
        checkOutput("rstReady", 64'(bus.ready_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        applyStimulus(OP_ADD, 32'd5, 32'd7, 1'b0);

        // Back-to-back single-cycle ops on consecutive edges.
        bbOp = '{OP_SUB, OP_AND, OP_OR};
        bbA  = '{32'd3, 32'h0000_F0F0, 32'h1};
        bbB  = '{32'd3, 32'h0000_0FF0, 32'h2};
        bus.valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ALUCtrl_i = bbOp[i];
            bus.data1_i   = bbA[i];
            bus.data2_i   = bbB[i];
            @(posedge clk_i); #1;
            bbRes = refResult(bbOp[i], bbA[i], bbB[i]);
            checkOutput($sformatf("b2bValid%0d", i), 64'(bus.valid_o), 64'd1);
            checkOutput($sformatf("b2bData%0d", i),  64'(bus.data_o),  64'(bbRes));
            checkOutput($sformatf("b2bZero%0d", i),  64'(bus.zero_o),  64'(bbRes == '0));
            checkOutput($sformatf("b2bReady%0d", i), 64'(bus.ready_o), 64'd1);
        end
        bus.valid_i = 1'b0;
        @(negedge clk_i);

        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'd6, 1'b0);

        // Reset mid-multiply must abort without ever producing a result.
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = OP_MUL;
        bus.data1_i   = 32'h0001_0000;
        bus.data2_i   = 32'h0001_0000;
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checkOutput("abortValid", 64'(bus.valid_o), 64'd0);
        checkOutput("abortData",  64'(bus.data_o),  64'd0);
        checkOutput("abortZero",  64'(bus.zero_o),  64'd1);
        checkOutput("abortErr",   64'(bus.err_o),   64'd0);
        checkOutput("abortReady", 64'(bus.ready_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (bus.valid_o) stray++;
        end
        checkOutput("abortNoStrayValid", 64'(stray), 64'd0);
        @(negedge clk_i);
        applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0);

        applyStimulus(3'b111, 32'd9, 32'd9, 1'b0);

        // valid_i held high with churning operands while multiplying.
        tA = $urandom;
        tB = $urandom;
        applyStimulus(OP_MUL, tA, tB, 1'b1);
        bus.ALUCtrl_i = OP_ADD;
        bus.data1_i   = 32'd100;
        bus.data2_i   = 32'd23;
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        checkOutput("busyFollowValid", 64'(bus.valid_o), 64'd1);
        checkOutput("busyFollowData",  64'(bus.data_o),  64'd123);
        @(negedge clk_i);

        for (int n = 0; n < 150; n++) begin
            tOp = randomOp();
            tA  = $urandom;
            tB  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
            applyStimulus(tOp, tA, tB, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
